scr1_ifu_prefetch: RTL and testbench
====================================

Name: scr1_ifu_prefetch

Overview:
- Instruction-fetch prefetch stage. Sits upstream of the IMEM AHB bridge and drives its core-side imem_req/imem_addr handshake.
- Issues sequential 32-bit fetches and tracks outstanding requests. Buffers returned words in a small queue and presents them to decode through a valid/ready interface.
- Handles PC redirects by flushing the queue and dropping the responses of fetches already in flight.

Parameters:
- QUEUE_DEPTH, 4: instruction queue entries (power of 2, >= 2).
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered imem requests (matches bridge request FIFO depth).
- RESET_PC, 32'h0000_0200: fetch address after reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- new_pc_req  in  1  redirect strobe; single-cycle.
- new_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req  out  1  fetch request to bridge.
- imem_addr  out  32  fetch address, word aligned.
- imem_req_ack  in  1  bridge accepts request this cycle.
- imem_rdata  in  32  response data.
- imem_resp  in  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER.
- ifu_valid  out  1  queue head valid.
- ifu_instr  out  32  queue head instruction.
- ifu_pc  out  32  queue head address.
- ifu_err  out  1  queue head came from an RDY_ER response.
- ifu_ready  in  1  decode consumes head when ifu_valid & ifu_ready.

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, outstanding=0, discard=0, queue empty, halted=0. Outputs: imem_req=0, ifu_valid=0, ifu_err=0.
- Request accept: a request is accepted in a cycle when imem_req & imem_req_ack.
- Issue condition: imem_req = ~halted & ~new_pc_req & (outstanding < MAX_OUTSTANDING) & (outstanding + q_count < QUEUE_DEPTH). This guarantees every response has a free slot, so there is no response backpressure.
- Address: imem_addr = fetch_pc. On accept, fetch_pc += 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- Each queue entry holds {pc, instr, err}. The pc is captured from a pc FIFO of depth MAX_OUTSTANDING, written on accept and read on each counted response.
- Counted response: imem_resp != NOTRDY.
  - If discard > 0: discard decrements, the pc FIFO pops, nothing is written to the queue.
  - Otherwise: write the entry with err = (imem_resp == RDY_ER). outstanding decrements.
  - outstanding changes by +accept -response in the same cycle (both may happen together).
- Error response: halted=1 and fetch stops. The error entry is still queued and delivered in order after older entries.
- Redirect (new_pc_req=1), effective next cycle:
  - fetch_pc=new_pc; queue cleared; halted=0.
  - discard = outstanding, minus 1 if a response arrives in the redirect cycle. outstanding and pc FIFO are left consistent.
  - No request is issued in the redirect cycle.
  - Any head consumed in the redirect cycle is still considered delivered.
- Queue timing: registered. A response written in cycle N is visible on ifu_valid in cycle N+1 (default).
  - Simultaneous push and pop while full is impossible by the issue rule.
  - Push and pop while non-empty: occupancy unchanged.
- Invariants:
  - outstanding <= MAX_OUTSTANDING.
  - q_count + outstanding - discard <= QUEUE_DEPTH.
  - A response with outstanding==0 is a protocol error (SVA under SCR1_SIM_ENV).

Optional Feature:
- SCR1_IFU_PREFETCH_BYPASS_EN.
- Defined: when the queue is empty, discard==0, and a counted response arrives, ifu_valid/ifu_instr/ifu_pc/ifu_err are driven combinationally from the response in the same cycle. If ifu_ready=1, the entry is not written to the queue. Zero-cycle fetch-to-decode latency.
- Undefined: always registered, one-cycle latency as above.

Test Plan:
- Reset release, bridge always acks with RDY_OK one cycle later, ifu_ready=1 -> addresses 0x200, 0x204, 0x208… in order; ifu_pc/ifu_instr match; first ifu_valid 2 cycles after first accept (1 with BYPASS_EN).
- ifu_ready=0 for 20 cycles -> exactly QUEUE_DEPTH=4 accepts, then imem_req=0. Raise ready -> 4 entries drain in order, then fetch resumes at 0x210.
- Two requests outstanding (0x300, 0x304), redirect to 0x1000 -> both responses dropped; first delivered ifu_pc=0x1000; no imem_addr 0x308 issued.
- Response RDY_ER for 0x208 -> entries 0x200, 0x204 delivered with ifu_err=0, then 0x208 with ifu_err=1; imem_req stays 0 until new_pc_req to 0x400, then fetch restarts at 0x400.
- Redirect cycle coincides with a response and an accept stall -> discard=outstanding-1, correct subsequent PC stream.
- fetch_pc=0xFFFF_FFF8 via redirect -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Assert rst mid-burst -> all outputs 0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/scr1_ifu_prefetch.sv
// Instruction-fetch prefetch stage: sequential IMEM fetch, pc tracking, instruction queue, redirect flush.
// Optional same-cycle response-to-decode bypass is enabled by defining SCR1_IFU_PREFETCH_BYPASS_EN.
package scr1_memif_pkg;
    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_ifu_prefetch
    import scr1_memif_pkg::*;
#(
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                new_pc_req,
    input  logic [31:0]         new_pc,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_req_ack,
    input  logic [31:0]         imem_rdata,
    input  type_scr1_mem_resp_e imem_resp,
    output logic                ifu_valid,
    output logic [31:0]         ifu_instr,
    output logic [31:0]         ifu_pc,
    output logic                ifu_err,
    input  logic                ifu_ready
);
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] discard_q, discard_d;
    logic          halted_q, halted_d;
    logic [31:0]   pcf_mem_q [MAX_OUTSTANDING];
    logic [31:0]   pcf_mem_d [MAX_OUTSTANDING];
    logic [PW-1:0] pcf_wr_q, pcf_wr_d;
    logic [PW-1:0] pcf_rd_q, pcf_rd_d;
    logic [31:0]   q_pc_q    [QUEUE_DEPTH];
    logic [31:0]   q_pc_d    [QUEUE_DEPTH];
    logic [31:0]   q_instr_q [QUEUE_DEPTH];
    logic [31:0]   q_instr_d [QUEUE_DEPTH];
    logic          q_err_q   [QUEUE_DEPTH];
    logic          q_err_d   [QUEUE_DEPTH];
    logic [QW-1:0] q_wr_q, q_wr_d;
    logic [QW-1:0] q_rd_q, q_rd_d;
    logic [CW-1:0] q_count_q, q_count_d;

    logic resp_cnt_s, resp_keep_s, resp_drop_s, resp_err_s;
    logic accept_s, push_s, pop_s, q_valid_s, bypass_s;

    function automatic logic [PW-1:0] pcf_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Handshakes, issue gating and decode-facing head selection.
    always_comb begin
        resp_cnt_s  = (imem_resp != SCR1_MEM_RESP_NOTRDY);
        resp_drop_s = resp_cnt_s & (discard_q != '0);
        resp_keep_s = resp_cnt_s & (discard_q == '0);
        resp_err_s  = (imem_resp == SCR1_MEM_RESP_RDY_ER);
        // Reserving a queue slot per outstanding fetch removes any need for response backpressure.
        imem_req    = ~rst & ~halted_q & ~new_pc_req
                    & (32'(outst_q) < 32'(MAX_OUTSTANDING))
                    & ((32'(outst_q) + 32'(q_count_q)) < 32'(QUEUE_DEPTH));
        imem_addr   = fetch_pc_q;
        accept_s    = imem_req & imem_req_ack;
        q_valid_s   = (q_count_q != '0);
        ifu_valid   = q_valid_s;
        ifu_instr   = q_instr_q[q_rd_q];
        ifu_pc      = q_pc_q[q_rd_q];
        ifu_err     = q_valid_s & q_err_q[q_rd_q];
        bypass_s    = 1'b0;
`ifdef SCR1_IFU_PREFETCH_BYPASS_EN
        if (~rst & ~q_valid_s & resp_keep_s) begin
            bypass_s  = 1'b1;
            ifu_valid = 1'b1;
            ifu_instr = imem_rdata;
            ifu_pc    = pcf_mem_q[pcf_rd_q];
            ifu_err   = resp_err_s;
        end else begin
            bypass_s  = 1'b0;
        end
`endif
        push_s      = resp_keep_s & ~new_pc_req & ~(bypass_s & ifu_ready);
        pop_s       = q_valid_s & ifu_ready;
    end

    // Next-state for fetch pointer, in-flight accounting and the pc FIFO.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + OW'(accept_s) - OW'(resp_cnt_s);
        discard_d  = discard_q;
        halted_d   = halted_q;
        pcf_mem_d  = pcf_mem_q;
        pcf_wr_d   = pcf_wr_q;
        pcf_rd_d   = pcf_rd_q;
        if (new_pc_req) begin
            fetch_pc_d = new_pc & 32'hFFFF_FFFC;
            // Everything still in flight after this cycle belongs to the old stream.
            discard_d  = outst_q - OW'(resp_cnt_s);
            halted_d   = 1'b0;
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (resp_drop_s) begin
                discard_d = discard_q - OW'(1);
            end else begin
                discard_d = discard_q;
            end
            if (resp_keep_s & resp_err_s) begin
                halted_d = 1'b1;
            end else begin
                halted_d = halted_q;
            end
        end
        if (accept_s) begin
            pcf_mem_d[pcf_wr_q] = fetch_pc_q;
            pcf_wr_d            = pcf_inc(pcf_wr_q);
        end else begin
            pcf_wr_d = pcf_wr_q;
        end
        if (resp_cnt_s) begin
            pcf_rd_d = pcf_inc(pcf_rd_q);
        end else begin
            pcf_rd_d = pcf_rd_q;
        end
    end

    // Next-state for the instruction queue.
    always_comb begin
        q_pc_d    = q_pc_q;
        q_instr_d = q_instr_q;
        q_err_d   = q_err_q;
        q_wr_d    = q_wr_q;
        q_rd_d    = q_rd_q;
        q_count_d = q_count_q;
        if (new_pc_req) begin
            q_wr_d    = '0;
            q_rd_d    = '0;
            q_count_d = '0;
        end else begin
            if (push_s) begin
                q_pc_d[q_wr_q]    = pcf_mem_q[pcf_rd_q];
                q_instr_d[q_wr_q] = imem_rdata;
                q_err_d[q_wr_q]   = resp_err_s;
                q_wr_d            = q_wr_q + QW'(1);
            end else begin
                q_wr_d = q_wr_q;
            end
            if (pop_s) begin
                q_rd_d = q_rd_q + QW'(1);
            end else begin
                q_rd_d = q_rd_q;
            end
            q_count_d = q_count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            halted_q   <= 1'b0;
            pcf_wr_q   <= '0;
            pcf_rd_q   <= '0;
            q_wr_q     <= '0;
            q_rd_q     <= '0;
            q_count_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                pcf_mem_q[i] <= 32'h0;
            end
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc_q[i]    <= 32'h0;
                q_instr_q[i] <= 32'h0;
                q_err_q[i]   <= 1'b0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            halted_q   <= halted_d;
            pcf_wr_q   <= pcf_wr_d;
            pcf_rd_q   <= pcf_rd_d;
            q_wr_q     <= q_wr_d;
            q_rd_q     <= q_rd_d;
            q_count_q  <= q_count_d;
            pcf_mem_q  <= pcf_mem_d;
            q_pc_q     <= q_pc_d;
            q_instr_q  <= q_instr_d;
            q_err_q    <= q_err_d;
        end
    end

`ifdef SCR1_SIM_ENV
    sva_resp_without_req: assert property (@(posedge clk) disable iff (rst)
        resp_cnt_s |-> (outst_q != '0));
    sva_outst_bound: assert property (@(posedge clk) disable iff (rst)
        32'(outst_q) <= 32'(MAX_OUTSTANDING));
`endif
endmodule

// File: tb/tb_scr1_ifu_prefetch.sv
// Scoreboard bench for scr1_ifu_prefetch: a bridge model answers fetches, a negedge monitor checks deliveries.
module tb_scr1_ifu_prefetch;
    import scr1_memif_pkg::*;

`ifdef SCR1_IFU_PREFETCH_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                new_pc_req;
    logic [31:0]         new_pc;
    logic                imem_req;
    logic [31:0]         imem_addr;
    logic                imem_req_ack;
    logic [31:0]         imem_rdata;
    type_scr1_mem_resp_e imem_resp;
    logic                ifu_valid;
    logic [31:0]         ifu_instr;
    logic [31:0]         ifu_pc;
    logic                ifu_err;
    logic                ifu_ready;

    logic        ack_en, resp_en;
    logic [31:0] err_addr, redir_addr, exp_next_addr, last_acc, bridge_addr;
    logic [31:0] pend[$];
    exp_t        exp_q[$];
    exp_t        e;
    int n_chk = 0, n_err = 0;
    int cyc = 0, acc_cnt = 0, err_cnt = 0;
    int first_acc_cyc = -1, first_val_cyc = -1;
    int flush_req = 0, flush_seen = 0;
    int acc0, err0;
    bit lat_arm = 1'b0, wrap_seen = 1'b0;

    scr1_ifu_prefetch dut (
        .clk          (clk),
        .rst          (rst),
        .new_pc_req   (new_pc_req),
        .new_pc       (new_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_req_ack (imem_req_ack),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .ifu_valid    (ifu_valid),
        .ifu_instr    (ifu_instr),
        .ifu_pc       (ifu_pc),
        .ifu_err      (ifu_err),
        .ifu_ready    (ifu_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_chk++;
        n_err++;
        $display("FAIL %s: got 0x%08h with nothing expected", name, act);
    endtask

    // Bridge model: acks per ack_en, answers each accepted fetch in order one cycle later when resp_en.
    initial begin
        imem_req_ack = 1'b0;
        imem_resp    = SCR1_MEM_RESP_NOTRDY;
        imem_rdata   = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                pend.delete();
                imem_resp  = SCR1_MEM_RESP_NOTRDY;
                imem_rdata = 32'h0;
            end else if (resp_en && pend.size() != 0) begin
                bridge_addr = pend.pop_front();
                imem_resp   = (bridge_addr == err_addr) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                imem_rdata  = mem_data(bridge_addr);
            end else begin
                imem_resp  = SCR1_MEM_RESP_NOTRDY;
                imem_rdata = 32'h0;
            end
            imem_req_ack = ack_en;
        end
    end

    // Scoreboard: flush on redirect/reset, check deliveries, check and record accepted fetches.
    initial begin
        forever begin
            @(negedge clk);
            if (flush_req != flush_seen) begin
                flush_seen    = flush_req;
                exp_q.delete();
                exp_next_addr = redir_addr;
            end
            if (lat_arm && ifu_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (ifu_valid && ifu_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_delivery", ifu_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("ifu_pc", ifu_pc, e.pc);
                    chk("ifu_instr", ifu_instr, e.instr);
                    chk("ifu_err", 32'(ifu_err), 32'(e.err));
                    if (ifu_err) err_cnt++;
                end
            end
            if (imem_req && imem_req_ack) begin
                chk("fetch_addr", imem_addr, exp_next_addr);
                if (exp_next_addr == 32'h0 && last_acc == 32'hFFFF_FFFC) wrap_seen = 1'b1;
                if (lat_arm && first_acc_cyc < 0) first_acc_cyc = cyc;
                exp_q.push_back('{pc: exp_next_addr, instr: mem_data(exp_next_addr),
                                  err: (exp_next_addr == err_addr)});
                pend.push_back(imem_addr);
                last_acc      = exp_next_addr;
                exp_next_addr = exp_next_addr + 32'd4;
                acc_cnt++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the redirect.
    task automatic redirect(input logic [31:0] a);
        new_pc_req = 1'b1;
        new_pc     = a;
        @(negedge clk);
        chk("req_in_redirect", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        new_pc_req = 1'b0;
        redir_addr = a;
        flush_req++;
    endtask

    task automatic quiesce();
        int n;
        ack_en    = 1'b0;
        resp_en   = 1'b1;
        ifu_ready = 1'b1;
        n = 0;
        while ((pend.size() != 0 || ifu_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) fail("quiesce_timeout", 32'(n));
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        new_pc_req    = 1'b0;
        new_pc        = 32'h0;
        ifu_ready     = 1'b1;
        ack_en        = 1'b0;
        resp_en       = 1'b1;
        err_addr      = 32'hFFFF_FFFF;
        exp_next_addr = 32'h200;
        redir_addr    = 32'h200;
        last_acc      = 32'h0;
        @(posedge clk);
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_ifu_valid", 32'(ifu_valid), 32'd0);
        chk("rst_ifu_err", 32'(ifu_err), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h200);

        // Streaming from RESET_PC with the bridge always answering.
        @(posedge clk);
        #1;
        ack_en  = 1'b1;
        lat_arm = 1'b1;
        rst     = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("first_valid_latency", 32'(first_val_cyc - first_acc_cyc), 32'(EXP_LAT));
        quiesce();

        // Decode stalled: queue fills to exactly 4, then drains in order and fetch resumes at 0x210.
        ifu_ready = 1'b0;
        ack_en    = 1'b1;
        acc0      = acc_cnt;
        redirect(32'h200);
        repeat (20) @(posedge clk);
        #1;
        chk("accepts_while_stalled", 32'(acc_cnt - acc0), 32'd4);
        @(negedge clk);
        chk("req_low_queue_full", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        ifu_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("fetch_resumed", 32'((acc_cnt - acc0) > 4), 32'd1);
        quiesce();

        // Two fetches held in flight, then redirect: both responses dropped.
        resp_en = 1'b0;
        ack_en  = 1'b1;
        acc0    = acc_cnt;
        redirect(32'h300);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("accepts_max_outstanding", 32'(acc_cnt - acc0), 32'd2);
        chk("req_low_max_outstanding", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        redirect(32'h1000);
        resp_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        quiesce();

        // Error response on 0x208: delivered in order with ifu_err, fetch halts until a redirect.
        err_addr = 32'h208;
        ack_en   = 1'b1;
        err0     = err_cnt;
        redirect(32'h200);
        repeat (10) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("req_low_halted", 32'(imem_req), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("error_entries_delivered", 32'(err_cnt - err0), 32'd1);
        chk("halt_queue_drained", 32'(exp_q.size()), 32'd0);
        err_addr = 32'hFFFF_FFFF;
        acc0     = acc_cnt;
        redirect(32'h400);
        repeat (6) @(posedge clk);
        #1;
        chk("restart_after_halt", 32'((acc_cnt - acc0) > 0), 32'd1);
        quiesce();

        // Redirect coincides with a response and an accept stall: one of two in-flight left to drop.
        resp_en = 1'b0;
        ack_en  = 1'b1;
        redirect(32'h500);
        repeat (3) @(posedge clk);
        #1;
        ack_en  = 1'b0;
        resp_en = 1'b1;
        redirect(32'h600);
        ack_en  = 1'b1;
        acc0    = acc_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("fetch_after_partial_discard", 32'((acc_cnt - acc0) > 2), 32'd1);
        quiesce();

        // Address wrap, then reset in the middle of a burst.
        ack_en = 1'b1;
        redirect(32'hFFFF_FFF8);
        repeat (6) @(posedge clk);
        #1;
        chk("addr_wrap_seen", 32'(wrap_seen), 32'd1);
        rst        = 1'b1;
        redir_addr = 32'h200;
        flush_req++;
        #3;
        chk("midrst_imem_req", 32'(imem_req), 32'd0);
        chk("midrst_ifu_valid", 32'(ifu_valid), 32'd0);
        chk("midrst_ifu_err", 32'(ifu_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        acc0 = acc_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("restart_after_reset", 32'((acc_cnt - acc0) > 0), 32'd1);
        quiesce();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
